display_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the multi-digit 7-segment display. It shares one combinational BCD-to-segment decoder across NUM_DIGITS common-anode digits. It holds a double-buffered display value and walks the digit index at a fixed rate, inserting a ghost-suppression blank at the start of every slot. It presents one nibble at a time on D, which feeds the decoder's D input directly.

---
 rtl/display_scan_ctrl.sv | 153 +++++++++++++++
 tb/tb_display_scan_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a multi-digit common-anode 7-segment
// display. One nibble at a time is presented on D to a shared BCD-to-segment
// decoder. The controller walks the digits at a fixed rate and inserts a
// ghost-suppression blank at the start of every digit slot.
//
// The display value is double-buffered. LOAD captures VALUE/DP into a pending
// buffer. The pending buffer is copied into the active buffer only at a frame
// boundary, so a frame never shows a mix of old and new data.
//
// Parameters
//   NUM_DIGITS  digits scanned (2..8)
//   SCAN_DIV    clock cycles per digit slot (>= 4)
//   BLANK_CYC   blank cycles at the start of each slot (1 <= BLANK_CYC < SCAN_DIV)
//
// Ports
//   CLK         system clock, rising edge
//   RST_N       synchronous active-low reset
//   VALUE       nibble k = digit k (digit 0 = rightmost)
//   DP          decimal point per digit, active high, captured with VALUE
//   LOAD        one-cycle strobe; captures VALUE/DP into the pending buffer
//   PENDING     pending buffer not yet applied to the display
//   D           nibble to the decoder; 4'hF = blank
//   DP_N        decimal point, active low
//   DIG_EN      digit enables, active low, at most one low at any time
//   FRAME_TICK  one-cycle pulse at each frame boundary
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, during the ON phase a digit k>0 shows
//                          D=4'hF when active nibbles k..NUM_DIGITS-1 are all 0.
//                          Its DIG_EN and DP_N behave as normal. Digit 0 is
//                          never blanked. Undefined: every nibble is shown as
//                          stored.
//
// Handshake: LOAD is a bare strobe with no ready. Every cycle LOAD is high is
// accepted, and the most recent capture before a frame boundary is the one
// that gets applied.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 100
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic                    LOAD,
  output logic                    PENDING,
  output logic [3:0]              D,
  output logic                    DP_N,
  output logic [NUM_DIGITS-1:0]   DIG_EN,
  output logic                    FRAME_TICK
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] act_val;
  logic [NUM_DIGITS-1:0]   act_dp;

  logic slot_end;
  logic frame_end;
  logic in_blank;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_blank  = (cnt < CNT_BLANK);

  // Select the active nibble/DP for the current digit, plus the
  // leading-zero blank decision when that option is built in.
  logic [3:0] cur_nib;
  logic       cur_dp;
  logic       cur_lz;

  always_comb begin
    cur_nib = 4'hF;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        cur_nib = act_val[4*k +: 4];
        cur_dp  = act_dp[k];
`ifdef LEADING_ZERO_BLANK_EN
        // Digit k is a leading zero when it and every digit above it is 0.
        cur_lz  = (k > 0) && ((act_val >> (4*k)) == '0);
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt        <= '0;
      idx        <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      PENDING    <= 1'b0;
      D          <= 4'hF;
      DP_N       <= 1'b1;
      DIG_EN     <= '1;
      FRAME_TICK <= 1'b0;
    end else begin
      // Slot / digit walk.
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_end ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Swap at the frame boundary uses the pending contents from before
      // this edge, so a LOAD on the boundary cycle waits one more frame.
      if (frame_end && PENDING) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end

      if (LOAD) begin
        pend_val <= VALUE;
        pend_dp  <= DP;
        PENDING  <= 1'b1;
      end else if (frame_end) begin
        PENDING  <= 1'b0;
      end

      // Registered outputs: reflect this cycle's cnt/idx.
      FRAME_TICK <= frame_end;
      if (in_blank) begin
        D      <= 4'hF;
        DP_N   <= 1'b1;
        DIG_EN <= '1;
      end else begin
        D      <= cur_lz ? 4'hF : cur_nib;
        DP_N   <= ~cur_dp;
        DIG_EN <= ~(NUM_DIGITS'(1) << idx);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Bench for display_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// The reference model works from the cycle number since reset release. The
// slot phase, digit and frame boundary come from plain division and modulo.
// The buffers are modelled as whole words.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 8;
  localparam int BLANK_CYC  = 2;
  localparam int FRAME      = NUM_DIGITS * SCAN_DIV;

  // ---------------- clock / reset ----------------
  logic                    CLK = 1'b0;
  logic                    RST_N;
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic [NUM_DIGITS-1:0]   DP;
  logic                    LOAD;
  logic                    PENDING;
  logic [3:0]              D;
  logic                    DP_N;
  logic [NUM_DIGITS-1:0]   DIG_EN;
  logic                    FRAME_TICK;

  always #5 CLK = ~CLK;

  display_scan_ctrl #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .VALUE     (VALUE),
    .DP        (DP),
    .LOAD      (LOAD),
    .PENDING   (PENDING),
    .D         (D),
    .DP_N      (DP_N),
    .DIG_EN    (DIG_EN),
    .FRAME_TICK(FRAME_TICK)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Expected word: {D[3:0], DP_N, DIG_EN[3:0], FRAME_TICK, PENDING}
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int                      m_k;        // edges since reset release
  logic [4*NUM_DIGITS-1:0] m_act_val;
  logic [NUM_DIGITS-1:0]   m_act_dp;
  logic [4*NUM_DIGITS-1:0] m_pend_val;
  logic [NUM_DIGITS-1:0]   m_pend_dp;
  logic                    m_pend;

  // ---------------- driver ----------------
  // Drives one cycle of inputs, predicts the outputs after the next rising
  // edge, then samples the DUT on the falling edge.
  task automatic step(input logic rst_i, input logic load_i,
                      input logic [4*NUM_DIGITS-1:0] val_i,
                      input logic [NUM_DIGITS-1:0] dp_i);
    logic [3:0]            e_d;
    logic                  e_dpn;
    logic [NUM_DIGITS-1:0] e_en;
    logic                  e_ft;
    logic [10:0]           e;
    logic                  one_low;
    int                    phase;
    int                    slot;
    logic                  boundary;

    RST_N = rst_i;
    LOAD  = load_i;
    VALUE = val_i;
    DP    = dp_i;

    e_d   = 4'hF;
    e_dpn = 1'b1;
    e_en  = '1;
    e_ft  = 1'b0;

    if (!rst_i) begin
      m_k        = 0;
      m_act_val  = '0;
      m_act_dp   = '0;
      m_pend_val = '0;
      m_pend_dp  = '0;
      m_pend     = 1'b0;
    end else begin
      phase    = m_k % SCAN_DIV;
      slot     = (m_k / SCAN_DIV) % NUM_DIGITS;
      boundary = ((m_k % FRAME) == FRAME - 1);
      e_ft     = boundary;
      if (phase >= BLANK_CYC) begin
        e_en       = '1;
        e_en[slot] = 1'b0;
        e_d        = 4'((m_act_val >> (4*slot)) & 16'hF);
        e_dpn      = ~m_act_dp[slot];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && (m_act_val >> (4*slot)) == 0) e_d = 4'hF;
`endif
      end
      if (boundary && m_pend) begin
        m_act_val = m_pend_val;
        m_act_dp  = m_pend_dp;
      end
      if (load_i) begin
        m_pend_val = val_i;
        m_pend_dp  = dp_i;
        m_pend     = 1'b1;
      end else if (boundary) begin
        m_pend = 1'b0;
      end
      m_k++;
    end

    exp_q.push_back({e_d, e_dpn, e_en, e_ft, m_pend});

    @(posedge CLK);
    @(negedge CLK);

    e = exp_q.pop_front();
    check("D",          32'(D),          32'(e[10:7]));
    check("DP_N",       32'(DP_N),       32'(e[6]));
    check("DIG_EN",     32'(DIG_EN),     32'(e[5:2]));
    check("FRAME_TICK", 32'(FRAME_TICK), 32'(e[1]));
    check("PENDING",    32'(PENDING),    32'(e[0]));
    one_low = ($countones(~DIG_EN) <= 1);
    check("DIG_EN_one_low", 32'(one_low), 32'(1));
  endtask

  // Idle cycle: VALUE/DP toggle randomly but must not be captured.
  task automatic idle();
    step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  // Idle until the next edge has the given position within the frame.
  task automatic advance_to(input int pos);
    for (int i = 0; i < FRAME && (m_k % FRAME) != pos; i++) idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 1'b0;
    LOAD  = 1'b0;
    VALUE = '0;
    DP    = '0;
    m_k        = 0;
    m_act_val  = '0;
    m_act_dp   = '0;
    m_pend_val = '0;
    m_pend_dp  = '0;
    m_pend     = 1'b0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);

    // Free-running scan of zeros, a bit over two frames.
    idle_n(70);

    // Mid-frame LOAD; shown in the frame after the next boundary.
    advance_to(10);
    step(1'b1, 1'b1, 16'h1234, 4'b0100);
    idle_n(80);

    // Two LOADs in one frame: the last one wins.
    advance_to(5);
    step(1'b1, 1'b1, 16'h1111, 4'b0001);
    idle_n(3);
    step(1'b1, 1'b1, 16'h9876, 4'b1000);
    idle_n(80);

    // LOAD on the exact boundary cycle while another value is pending.
    advance_to(20);
    step(1'b1, 1'b1, 16'h5555, 4'b0000);
    advance_to(FRAME - 1);
    step(1'b1, 1'b1, 16'h0042, 4'b0010);
    idle_n(100);

    // All-zero value: digit 0 still shows 0.
    advance_to(3);
    step(1'b1, 1'b1, 16'h0000, 4'b0000);
    idle_n(70);

    // Reset pulse during the digit-2 ON phase with a LOAD pending.
    advance_to(9);
    step(1'b1, 1'b1, 16'hABCD, 4'b1111);
    idle_n(FRAME + 2);
    step(1'b1, 1'b1, 16'h7777, 4'b0011);
    advance_to(2*SCAN_DIV + BLANK_CYC + 2);
    step(1'b0, 1'b0, 16'h0000, 4'b0000);
    idle_n(70);

    // Long random-LOAD run.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0)
        step(1'b1, 1'b1, 16'($urandom), 4'($urandom));
      else
        idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
